uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter. Supports configurable data width, optional odd/even parity and 1 or 2 stop bits. A small input FIFO with a valid/ready handshake lets queued words go out back-to-back with no idle gap. It sits between the on-board data source and the board-to-board serial line.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), must be >= 2 (elaboration error otherwise)
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input queue entries, power of two, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO can accept a word (= not full)
serial_out  out  1  serial line, idle high
tx_active  out  1  a frame is on the line
tx_done  out  1  one-cycle pulse, last cycle of a frame's final stop bit
fifo_count  out  clog2(FIFO_DEPTH)+1  words queued, not counting the frame in flight

Behaviour:
- Reset (async assert, sync release): serial_out=1, tx_active=0, tx_done=0, fifo_count=0, tx_ready=1, FSM=IDLE, baud and bit counters cleared, FIFO emptied. Reset mid-frame aborts the frame; the line returns high immediately.
- Accept: a word is taken on an edge where tx_valid and tx_ready are both high. It is written into the FIFO and fifo_count increments on that edge. tx_data is don't-care afterwards.
- FIFO full: tx_ready=0 and pushes are ignored. Push and pop on the same edge leave fifo_count unchanged. Pop happens only when the FIFO is non-empty, so a push into an empty FIFO is never popped on the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: serial_out=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - Latency: accept at edge N with the FIFO empty and the FSM idle; the pop occurs at edge N+1; serial_out=0 from edge N+2.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: bits are sent LSB first, bit i held for CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if PARITY!=0, otherwise STOP.
- PARITY: sends one bit for CLKS_PER_BIT cycles.
  - even: bit = XOR of the data bits.
  - odd: bit = inverted XOR of the data bits.
- STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the final cycle of STOP. On that same edge:
  - FIFO non-empty: pop, go straight to START (zero gap, tx_active stays 1).
  - FIFO empty: go to IDLE.
- tx_active: 1 from the edge entering START until the edge leaving STOP for IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Counter widths:
  - baud counter: clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.
  - bit counter: clog2(DATA_BITS) bits.
  - stop counter: 1 bit.
  - No counter may overflow for any legal parameter set.

Decomposition:
- Shared package uart_pkg:
  - parity constants PARITY_NONE/PARITY_ODD/PARITY_EVEN
  - FSM state encoding (3-bit)
  - function clks_per_bit(clk_freq, baud)
  - clog2 helper
  (Reused by the future uart_rx_param.)
- Sub-module uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, count; same clk/rst_n.
- The FSM, shifter and parity logic stay in uart_tx_param.

Test Plan:
All cases use CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10) unless noted.
- DATA_BITS=8, PARITY=0, STOP_BITS=1. Send 8'hA5 -> serial_out low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10. Frame is 100 cycles; tx_done pulses in cycle 100; start bit begins 2 cycles after accept.
- PARITY=2, send 8'h07 -> parity bit 1, frame 110 cycles. PARITY=1, send 8'h07 -> parity bit 0.
- FIFO_DEPTH=4, tx_valid held high with 5 words while idle:
  - tx_ready drops when the FIFO is full.
  - All words are eventually sent as contiguous frames with no high gap beyond the stop bit.
  - tx_active stays 1 throughout; 5 tx_done pulses 100 cycles apart; fifo_count returns to 0.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, send 7'h41 -> bits 1,0,0,0,0,0,1, parity 1, two stop bits. Frame is 110 cycles; tx_done in the final stop cycle only.
- Assert rst_n=0 during data bit 3 with 2 words queued:
  - Outputs take reset values immediately (serial_out=1, fifo_count=0, tx_active=0).
  - After release, sending 8'h3C produces one clean 100-cycle frame.
- Change tx_data on the edge after acceptance -> the originally accepted value is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, FSM encoding and sizing helpers for the UART blocks
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two synchronous FIFO; pushes when full and pops when empty are ignored
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: queued UART transmitter with configurable width, parity and stop bits
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW = clog2(CPB);
  localparam int NW = clog2(DATA_BITS);
  if (CPB < 2) begin : g_bad_baud
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end
  state_t state, state_n;
  logic [BW-1:0] baud;
  logic [NW-1:0] bit_idx;
  logic stop_idx;
  logic [DATA_BITS-1:0] shreg, fifo_rdata;
  logic par_bit, fifo_full, fifo_empty, pop, bit_end, frame_end;
  assign bit_end = baud == BW'(CPB - 1);
  assign tx_ready = !fifo_full;
  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(tx_valid),
    .pop(pop),
    .wdata(tx_data),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  // next state; the last stop cycle pops the next word so frames run back to back
  always_comb begin
    state_n = state;
    pop = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        pop = !fifo_empty;
        state_n = fifo_empty ? S_IDLE : S_START;
      end
      S_START: state_n = bit_end ? S_DATA : S_START;
      S_DATA: begin
        if (bit_end && bit_idx == NW'(DATA_BITS - 1))
          state_n = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
      end
      S_PARITY: state_n = bit_end ? S_STOP : S_PARITY;
      S_STOP: begin
        if (bit_end && stop_idx == 1'(STOP_BITS - 1)) begin
          frame_end = 1'b1;
          pop = !fifo_empty;
          state_n = fifo_empty ? S_IDLE : S_START;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  // counters, shifter and registered line outputs; the line follows the state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      shreg <= '0;
      par_bit <= 1'b0;
      serial_out <= 1'b1;
      tx_active <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      baud <= (state == S_IDLE || bit_end) ? '0 : baud + BW'(1);
      bit_idx <= state_n != S_DATA ? '0 : (state == S_DATA && bit_end) ? bit_idx + NW'(1) : bit_idx;
      stop_idx <= state_n != S_STOP ? 1'b0 : (state == S_STOP && bit_end) ? 1'b1 : stop_idx;
      shreg <= pop ? fifo_rdata : (state == S_DATA && bit_end) ? shreg >> 1 : shreg;
      par_bit <= pop ? (^fifo_rdata) ^ (PARITY == PARITY_ODD) : par_bit;
      serial_out <= state == S_START ? 1'b0 : state == S_DATA ? shreg[0] : state == S_PARITY ? par_bit : 1'b1;
      tx_active <= state_n != S_IDLE;
      tx_done <= frame_end;
    end
  end
endmodule
